// File: rtl/data_memory_shady_mohamed_19100178.sv
// -----------------------------------------------------------------------------
// data_memory_shady_mohamed_19100178
//
// Purpose:
//   Single-port, word-organised data memory for a simple processor datapath.
//   Writes happen on the rising clock edge. Reads are purely combinational,
//   so a load sees the stored word in the same cycle it is requested.
//   A synchronous reset clears every word.
//
// Parameters:
//   DEPTH : number of 32-bit words stored (default 256)
//   AW    : word-index width, must equal log2(DEPTH) (default 8)
//
// Ports:
//   clk    in   1   single clock, all state changes on the rising edge
//   rst    in   1   synchronous, active-high reset (clears all words)
//   addr   in  32   byte address, normally the ALU result
//   w_data in  32   store data
//   r_data out 32   load data (combinational, zero when not reading)
//   mem_w  in   1   write enable
//   mem_r  in   1   read enable
//
// Configuration macro:
//   DMEM_ALIGN_CHECK_EN : when defined, any access with addr[1:0] != 0 is
//                         rejected (write ignored, read returns zero). When
//                         undefined, the two low address bits are ignored and
//                         a misaligned access hits the containing word.
// -----------------------------------------------------------------------------
module data_memory_shady_mohamed_19100178 #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] w_data,
    output logic [31:0] r_data,
    input  logic        mem_w,
    input  logic        mem_r
);

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] index;
    logic          in_range;
    logic          aligned;
    logic          access_ok;

    // Word index comes from the bits just above the byte offset.
    assign index = addr[AW+1:2];

    // An address is valid only if every bit above the indexed range is zero,
    // so addresses at or beyond DEPTH*4 never wrap back onto low words.
    assign in_range = ((addr >> (AW + 2)) == 32'd0);

    // Alignment only matters when the check is compiled in; otherwise the
    // low byte-offset bits are simply dropped.
    assign aligned   = (addr[1:0] == 2'b00) || !ALIGN_CHECK;
    assign access_ok = in_range && aligned;

    // Storage update: reset wins over any write requested in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (mem_w && access_ok) begin
            mem[index] <= w_data;
        end
    end

    // Combinational load path: the old word is visible until the write edge.
    always_comb begin
        r_data = 32'h0;
        if (mem_r && access_ok) begin
            r_data = mem[index];
        end
    end

endmodule

// File: tb/tb_data_memory_shady_mohamed_19100178.sv
// -----------------------------------------------------------------------------
// tb_data_memory_shady_mohamed_19100178
//
// Purpose:
//   Self-checking bench for data_memory_shady_mohamed_19100178. A word-array
//   model of the memory follows the behavioural rules (byte address / 4,
//   range limit of 1024 bytes, reset clears all, reset beats write). A compare
//   process checks r_data against the model every cycle, and directed steps
//   add literal expected values.
//
// Configuration macro:
//   DMEM_ALIGN_CHECK_EN : must match the DUT build; selects the expected
//                         values for misaligned accesses.
// -----------------------------------------------------------------------------
module tb_data_memory_shady_mohamed_19100178;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [31:0] r_data;
    logic        mem_w;
    logic        mem_r;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    logic [31:0] model_mem [256];

    data_memory_shady_mohamed_19100178 #(
        .DEPTH(256),
        .AW   (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .w_data(w_data),
        .r_data(r_data),
        .mem_w (mem_w),
        .mem_r (mem_r)
    );

    always #5 clk = ~clk;

    // True when the byte address reaches a stored word under the build's rules.
    function automatic bit model_hit(input logic [31:0] a);
        bit hit;
        hit = (a < 32'd1024);
`ifdef DMEM_ALIGN_CHECK_EN
        hit = hit && ((a % 4) == 0);
`endif
        return hit;
    endfunction

    function automatic logic [7:0] model_word(input logic [31:0] a);
        return 8'(a / 4);
    endfunction

    function automatic logic [31:0] model_read();
        if (mem_r && model_hit(addr)) begin
            return model_mem[model_word(addr)];
        end
        return 32'h0;
    endfunction

    // Model storage follows every rising edge.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            for (int i = 0; i < 256; i++) begin
                model_mem[i] <= 32'h0;
            end
        end else if (mem_w === 1'b1 && model_hit(addr)) begin
            model_mem[model_word(addr)] <= w_data;
        end
    end

    // Every-cycle comparison of the load path against the model.
    always @(negedge clk) begin
        if (check_en) begin
            vectors++;
            if (r_data !== model_read()) begin
                miscompares++;
                $display("[TB] FAIL cycle_compare addr=%h mem_r=%b got=%h expected=%h",
                         addr, mem_r, r_data, model_read());
            end
        end
    end

    // Drive one cycle of inputs just after a rising edge.
    task automatic applyStimulus(input logic r, input logic w, input logic rd,
                                 input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst    = r;
        mem_w  = w;
        mem_r  = rd;
        addr   = a;
        w_data = d;
    endtask

    // Literal check taken in the middle of the current cycle.
    task automatic checkOutput(input string name, input logic [31:0] expected);
        @(negedge clk);
        #1;
        vectors++;
        if (r_data !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s addr=%h got=%h expected=%h", name, addr, r_data, expected);
        end
    endtask

    logic [31:0] exp_misaligned_read;
    logic [31:0] exp_after_misaligned_write;
    logic [31:0] loop_addr;

    initial begin
`ifdef DMEM_ALIGN_CHECK_EN
        exp_misaligned_read        = 32'h0000_0000;
        exp_after_misaligned_write = 32'hCAFE_F00D;
`else
        exp_misaligned_read        = 32'hCAFE_F00D;
        exp_after_misaligned_write = 32'h0000_0001;
`endif
        rst    = 1'b1;
        mem_w  = 1'b0;
        mem_r  = 1'b0;
        addr   = 32'h0;
        w_data = 32'h0;
        @(posedge clk);
        #1;
        check_en = 1'b1;

        // Reset state, lowest and highest word.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0);
        checkOutput("reset_word0", 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_03FC, 32'h0);
        checkOutput("reset_word255", 32'h0);

        // Basic write then read, then read disabled.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
        checkOutput("read_after_write", 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
        checkOutput("read_disabled", 32'h0);

        // Read-before-write in the same cycle.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h1111_1111);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h2222_2222);
        checkOutput("rbw_old_word", 32'h1111_1111);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h0);
        checkOutput("rbw_new_word", 32'h2222_2222);

        // Out-of-range writes must not alias onto low words.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0410, 32'hAAAA_5555);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h5555_AAAA);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0);
        checkOutput("oor_word0", 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_03FC, 32'h0);
        checkOutput("oor_word255", 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h0);
        checkOutput("oor_read", 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
        checkOutput("oor_no_alias", 32'hDEAD_BEEF);

        // Topmost valid word is writable.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_03FC, 32'h0BAD_F00D);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_03FC, 32'h0);
        checkOutput("top_word", 32'h0BAD_F00D);

        // Misaligned accesses.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'hCAFE_F00D);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0006, 32'h0);
        checkOutput("misaligned_read", exp_misaligned_read);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_0001);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h0);
        checkOutput("misaligned_write", exp_after_misaligned_write);

        // mem_w low never modifies storage.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h0);
        checkOutput("no_write_enable", exp_after_misaligned_write);

        // A pattern of words at spread-out addresses.
        for (int i = 0; i < 8; i++) begin
            loop_addr = 32'(i * 36);
            applyStimulus(1'b0, 1'b1, 1'b0, loop_addr, 32'h1000_0000 + 32'(i) * 32'h0101_0101);
        end
        for (int i = 0; i < 8; i++) begin
            loop_addr = 32'(i * 36);
            applyStimulus(1'b0, 1'b0, 1'b1, loop_addr, 32'h0);
            checkOutput("pattern_word", 32'h1000_0000 + 32'(i) * 32'h0101_0101);
        end

        // Reset in the same cycle as a write discards the write and clears all.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h1234_5678);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h0);
        checkOutput("reset_beats_write", 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
        checkOutput("reset_clears_all", 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_03FC, 32'h0);
        checkOutput("reset_clears_top", 32'h0);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        #2;
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_memory_shady_mohamed_19100178.md
DATA_MEMORY_SHADY_MOHAMED_19100178 -- requirements
Module: data_memory_shady_mohamed_19100178

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words stored.
REQ-002 Parameter AW, default 8: word-index width, SHALL equal log2(DEPTH).
REQ-003 clk  input  1: single clock; all state changes on rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 addr  input  32: byte address from ALU result.
REQ-006 w_data  input  32: store data.
REQ-007 r_data  output  32: load data.
REQ-008 mem_w  input  1: write enable.
REQ-009 mem_r  input  1: read enable.

Function
REQ-010 Storage SHALL be DEPTH words of 32 bits, word-addressed by index addr[AW+1:2].
REQ-011 addr[1:0] SHALL be ignored for indexing; accesses are whole-word only.
REQ-012 An address is in range iff addr < DEPTH*4; upper bits beyond range SHALL NOT alias.
REQ-013 Write: at rising clk with mem_w=1, rst=0, in-range addr, word[index] SHALL take w_data.
REQ-014 Out-of-range writes SHALL leave all storage unchanged.
REQ-015 Read: r_data SHALL be combinational, equal to word[index] while mem_r=1 and addr in range, zero latency.
REQ-016 r_data SHALL be 32'h0 when mem_r=0 or addr out of range.
REQ-017 mem_r and mem_w both 1, same address: r_data SHALL show old word until the edge, new word after it (read-before-write within the cycle).
REQ-018 mem_w=0 SHALL never modify storage regardless of addr/w_data.
REQ-019 No X SHALL appear on r_data after reset for any input combination with known values.

Reset
REQ-020 At rising clk with rst=1, every word SHALL become 32'h0; a write requested in the same cycle SHALL be discarded.
REQ-021 rst asserted mid-sequence SHALL take effect at the next edge, overriding mem_w.
REQ-022 r_data has no register; after reset it SHALL read 32'h0 for any in-range address with mem_r=1.

Configuration
REQ-023 Macro DMEM_ALIGN_CHECK_EN SHALL control alignment enforcement.
REQ-024 With DMEM_ALIGN_CHECK_EN defined: addr[1:0]!=0 SHALL make writes ignored and r_data 32'h0.
REQ-025 Without it: addr[1:0] SHALL be ignored per REQ-011 and misaligned accesses hit the containing word.

Verification
REQ-026 rst=1 one edge, then mem_r=1, addr=0x0 and addr=0x3FC -> r_data=0x00000000 both.
REQ-027 mem_w=1, addr=0x10, w_data=0xDEADBEEF, edge; mem_w=0, mem_r=1, addr=0x10 -> r_data=0xDEADBEEF; mem_r=0 -> 0x00000000.
REQ-028 mem_r=1, mem_w=1, addr=0x20 holding 0x11111111, w_data=0x22222222 -> 0x11111111 before edge, 0x22222222 after.
REQ-029 mem_w=1, addr=0x400, w_data=0xFFFFFFFF, edge -> addr=0x0 and 0x3FC still read 0x00000000; read of 0x400 -> 0x00000000.
REQ-030 mem_w=1, rst=1, addr=0x8, w_data=0x12345678, edge; rst=0, read 0x8 -> 0x00000000.
REQ-031 Write 0xCAFEF00D at addr=0x4, read addr=0x6 -> 0xCAFEF00D without macro, 0x00000000 with DMEM_ALIGN_CHECK_EN; a write of 0x1 at addr=0x5 leaves 0x4 unchanged only with macro.
